tim6_counter_core: RTL

Counting engine of the basic timer TIM6. It consumes the latched 5-bit CR1 control word {ARPE, OPM, URS, UDIS, CEN} and the PSC/ARR/CNT register writes. It runs the prescaler and the 16-bit up-counter, generates update events (UEV), maintains the UIF status flag and the interrupt request, and issues a CEN-clear pulse back to the CR1 register in one-pulse mode.

---
 rtl/tim6_counter_core.sv | 132 +++++++++++++
 1 files changed

// File: rtl/tim6_counter_core.sv
// TIM6 counting engine: prescaler, 16-bit up-counter, update events, UIF/IRQ and one-pulse stop.
// Optional DMA request path is built when TIM6_DMA_EN is defined.
module tim6_counter_core #(
  parameter int unsigned      CNT_W   = 16,
  parameter logic [CNT_W-1:0] ARR_RST = {CNT_W{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       i_tim6_cr1,
  input  logic             i_uie,
  input  logic             i_psc_wr,
  input  logic             i_arr_wr,
  input  logic             i_cnt_wr,
  input  logic [CNT_W-1:0] i_wdata,
  input  logic             i_ug,
  input  logic             i_uif_clr,
  output logic [CNT_W-1:0] o_cnt,
  output logic [CNT_W-1:0] o_psc,
  output logic [CNT_W-1:0] o_arr,
  output logic             o_uif,
  output logic             o_uev,
  output logic             o_irq,
  output logic             o_cen_clr
`ifdef TIM6_DMA_EN
  ,
  input  logic             i_ude,
  input  logic             i_dma_ack,
  output logic             o_dma_req
`endif
);

  logic cen, udis, urs, opm, arpe;
  assign {arpe, opm, urs, udis, cen} = i_tim6_cr1;

  logic [CNT_W-1:0] cnt_q, cnt_d, pc_q, pc_d;
  logic [CNT_W-1:0] psc_pre_q, psc_pre_d, psc_sh_q, psc_sh_d;
  logic [CNT_W-1:0] arr_pre_q, arr_pre_d, arr_sh_q, arr_sh_d;
  logic             uif_q, uif_d, uev_q, uev_d, cen_clr_q, cen_clr_d, halt_q, halt_d;

  logic run_c, tick_c, ovf_c, upd_c, uif_set_c;

  // Tick when the prescaler reaches its shadow; overflow only on a tick that UG/CNT write do not override.
  assign run_c     = cen & ~halt_q;
  assign tick_c    = run_c & (pc_q == psc_sh_q);
  assign ovf_c     = tick_c & ~i_ug & ~i_cnt_wr & (arr_sh_q != '0) & (cnt_q >= arr_sh_q);
  assign upd_c     = ~udis & (i_ug | ovf_c);
  assign uif_set_c = ~udis & (ovf_c | (i_ug & ~urs));

  always_comb begin
    cnt_d     = cnt_q;
    pc_d      = pc_q;
    psc_pre_d = psc_pre_q;
    psc_sh_d  = psc_sh_q;
    arr_pre_d = arr_pre_q;
    arr_sh_d  = arr_sh_q;
    uif_d     = uif_q;
    halt_d    = halt_q;
    uev_d     = upd_c;
    cen_clr_d = upd_c & opm;

    if (i_psc_wr) psc_pre_d = i_wdata;
    if (i_arr_wr) arr_pre_d = i_wdata;

    if (i_ug) begin
      cnt_d = '0;
      pc_d  = '0;
    end else begin
      if (run_c) pc_d = tick_c ? '0 : CNT_W'(pc_q + CNT_W'(1));
      if (i_cnt_wr) cnt_d = i_wdata;
      else if (tick_c && (arr_sh_q != '0)) cnt_d = ovf_c ? '0 : CNT_W'(cnt_q + CNT_W'(1));
    end

    // Shadows take the preload value that was present before this clock's writes.
    if (upd_c) begin
      psc_sh_d = psc_pre_q;
      if (arpe) arr_sh_d = arr_pre_q;
    end
    if (i_arr_wr && !arpe) arr_sh_d = i_wdata;

    if (uif_set_c)      uif_d = 1'b1;
    else if (i_uif_clr) uif_d = 1'b0;

    if (!cen)             halt_d = 1'b0;
    else if (upd_c && opm) halt_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      pc_q      <= '0;
      psc_pre_q <= '0;
      psc_sh_q  <= '0;
      arr_pre_q <= ARR_RST;
      arr_sh_q  <= ARR_RST;
      uif_q     <= 1'b0;
      uev_q     <= 1'b0;
      cen_clr_q <= 1'b0;
      halt_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pc_q      <= pc_d;
      psc_pre_q <= psc_pre_d;
      psc_sh_q  <= psc_sh_d;
      arr_pre_q <= arr_pre_d;
      arr_sh_q  <= arr_sh_d;
      uif_q     <= uif_d;
      uev_q     <= uev_d;
      cen_clr_q <= cen_clr_d;
      halt_q    <= halt_d;
    end
  end

`ifdef TIM6_DMA_EN
  logic dma_q;
  // Request latches on any update event (UG included, URS ignored) and holds until acknowledged.
  always_ff @(posedge clk) begin
    if (rst)                 dma_q <= 1'b0;
    else if (upd_c && i_ude) dma_q <= 1'b1;
    else if (i_dma_ack)      dma_q <= 1'b0;
  end
  assign o_dma_req = dma_q;
`endif

  assign o_cnt     = cnt_q;
  assign o_psc     = psc_pre_q;
  assign o_arr     = arr_pre_q;
  assign o_uif     = uif_q;
  assign o_uev     = uev_q;
  assign o_cen_clr = cen_clr_q;
  assign o_irq     = uif_q & i_uie;

endmodule
